// File: rtl/gpio_bfm_stim_capture_if.sv
// rtl/gpio_bfm_stim_capture_if.sv - BFM external-memory bus bundle for the GPIO stim/capture agent
// Purpose: groups the BFM word-addressed register bus into one interface.
// Signals:
//    BFM_WR    one-cycle write strobe
//    BFM_RD    one-cycle read strobe
//    BFM_ADDR  word address
//    BFM_WDATA write data
//    BFM_RDATA read data (combinational from BFM_ADDR)
// Modports: master (BFM side), slave (agent side).
interface gpio_bfm_stim_capture_if;
   logic        BFM_WR;
   logic        BFM_RD;
   logic [31:0] BFM_ADDR;
   logic [31:0] BFM_WDATA;
   logic [31:0] BFM_RDATA;

   modport master (output BFM_WR, output BFM_RD, output BFM_ADDR, output BFM_WDATA,
                   input  BFM_RDATA);
   modport slave  (input  BFM_WR, input  BFM_RD, input  BFM_ADDR, input  BFM_WDATA,
                   output BFM_RDATA);
endinterface

// File: rtl/gpio_bfm_stim_capture.sv
// rtl/gpio_bfm_stim_capture.sv - GPIO pulse-train stimulus and edge-capture agent
// Purpose: drives GPIO_IN with a programmable pulse train and timestamps changes
//    on GPIO_OUT or INT into a FIFO, all controlled through word-addressed registers.
// Ports:
//    SYSCLK_apb  clock, rising edge
//    PRESETN     asynchronous active-low reset
//    bfm         register bus (slave modport)
//    GPIO_IN     drive to DUT GPIO_IN
//    GPIO_OUT    DUT output observe
//    GPIO_OE     DUT output-enable observe
//    INT         DUT interrupt observe
//    STIM_BUSY   pulse train active
//    CAP_OVF     sticky capture FIFO overflow
module gpio_bfm_stim_capture #(
   parameter int IO_NUM     = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int TS_WIDTH   = 16
) (
   input  logic                   SYSCLK_apb,
   input  logic                   PRESETN,
   gpio_bfm_stim_capture_if.slave bfm,
   output logic [IO_NUM-1:0]      GPIO_IN,
   input  logic [IO_NUM-1:0]      GPIO_OUT,
   input  logic [IO_NUM-1:0]      GPIO_OE,
   input  logic [IO_NUM-1:0]      INT,
   output logic                   STIM_BUSY,
   output logic                   CAP_OVF
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int EW = TS_WIDTH + IO_NUM;

   typedef enum logic [1:0] {ST_IDLE, ST_HI, ST_LO} pstate_t;

   // register decode
   logic       addr_hit;
   logic [3:0] reg_idx;
   logic       wr_base, wr_pmask, wr_pctrl, wr_cctrl, rd_pop;
   assign addr_hit = (bfm.BFM_ADDR[31:4] == 28'd0);
   assign reg_idx  = bfm.BFM_ADDR[3:0];
   assign wr_base  = bfm.BFM_WR & addr_hit & (reg_idx == 4'h0);
   assign wr_pmask = bfm.BFM_WR & addr_hit & (reg_idx == 4'h4);
   assign wr_pctrl = bfm.BFM_WR & addr_hit & (reg_idx == 4'h5);
   assign wr_cctrl = bfm.BFM_WR & addr_hit & (reg_idx == 4'h6);
   assign rd_pop   = bfm.BFM_RD & addr_hit & (reg_idx == 4'h8);

   logic unused_wdata;
   assign unused_wdata = ^bfm.BFM_WDATA;

   // pulse train FSM
   pstate_t     state_q;
   logic [15:0] width_q, cnt_q;
   logic [7:0]  num_q;
   logic        busy_q;

   always_ff @(posedge SYSCLK_apb or negedge PRESETN) begin
      if (!PRESETN) begin
         state_q <= ST_IDLE;
         width_q <= 16'd0;
         cnt_q   <= 16'd0;
         num_q   <= 8'd0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               // a start with zero pulses is a no-op; zero width behaves as one
               if (wr_pctrl && (bfm.BFM_WDATA[23:16] != 8'd0)) begin
                  state_q <= ST_HI;
                  width_q <= (bfm.BFM_WDATA[15:0] == 16'd0) ? 16'd1 : bfm.BFM_WDATA[15:0];
                  num_q   <= bfm.BFM_WDATA[23:16];
                  cnt_q   <= 16'd0;
                  busy_q  <= 1'b1;
               end
            end
            ST_HI: begin
               if (cnt_q == width_q - 16'd1) begin
                  cnt_q   <= 16'd0;
                  state_q <= ST_LO;
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            ST_LO: begin
               if (cnt_q == width_q - 16'd1) begin
                  cnt_q   <= 16'd0;
                  num_q   <= num_q - 8'd1;
                  state_q <= (num_q == 8'd1) ? ST_IDLE : ST_HI;
                  busy_q  <= (num_q != 8'd1);
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   logic phase;
   assign phase = (state_q == ST_HI);

   // datapath registers
   logic [IO_NUM-1:0]   base_q, base_d, pmask_q, pmask_d, gpio_in_q, gpio_in_d, prev_q, prev_d;
   logic                cap_en_q, cap_en_d, cap_src_q, cap_src_d, ovf_q, ovf_d;
   logic [TS_WIDTH-1:0] ts_q, ts_d;
   logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [8:0]          count_q, count_d;
   logic [EW-1:0]       mem_q [FIFO_DEPTH];

   logic [IO_NUM-1:0] cap_cur, cap_new;
   logic              cap_empty, cap_full, reload, push, pop, clear, mem_we;
   logic [EW-1:0]     head;

   assign cap_empty = (count_q == 9'd0);
   assign cap_full  = (count_q == 9'(FIFO_DEPTH));
   assign cap_cur   = cap_src_q ? INT : GPIO_OUT;
   assign cap_new   = bfm.BFM_WDATA[1] ? INT : GPIO_OUT;
   assign head      = mem_q[rd_ptr_q];

   always_comb begin
      base_d    = base_q;
      pmask_d   = pmask_q;
      cap_en_d  = cap_en_q;
      cap_src_d = cap_src_q;
      prev_d    = prev_q;
      ts_d      = ts_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      ovf_d     = ovf_q;
      mem_we    = 1'b0;

      if (wr_base)  base_d  = bfm.BFM_WDATA[IO_NUM-1:0];
      if (wr_pmask) pmask_d = bfm.BFM_WDATA[IO_NUM-1:0];
      gpio_in_d = base_q ^ (pmask_q & {IO_NUM{phase}});

      if (wr_cctrl) begin
         cap_en_d  = bfm.BFM_WDATA[0];
         cap_src_d = bfm.BFM_WDATA[1];
      end
      // enabling, or switching source while enabled, re-baselines prev without a push
      reload = wr_cctrl & bfm.BFM_WDATA[0] & (~cap_en_q | (bfm.BFM_WDATA[1] != cap_src_q));
      push   = cap_en_q & ~reload & (cap_cur != prev_q);
      pop    = rd_pop & ~cap_empty;
      clear  = wr_cctrl & bfm.BFM_WDATA[2];

      if (reload)    prev_d = cap_new;
      else if (push) prev_d = cap_cur;

      if (wr_cctrl && bfm.BFM_WDATA[0] && !cap_en_q) ts_d = '0;
      else if (cap_en_q)                             ts_d = ts_q + TS_WIDTH'(1);

      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = 9'd0;
         ovf_d    = 1'b0;
      end else begin
         // a pop frees the slot a same-cycle push needs, so full+push+pop is legal
         mem_we = push & (~cap_full | pop);
         if (push && cap_full && !pop) ovf_d = 1'b1;
         if (mem_we) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)    rd_ptr_d = rd_ptr_q + AW'(1);
         if (mem_we && !pop)      count_d = count_q + 9'd1;
         else if (pop && !mem_we) count_d = count_q - 9'd1;
      end
   end

   always_ff @(posedge SYSCLK_apb or negedge PRESETN) begin
      if (!PRESETN) begin
         base_q    <= '0;
         pmask_q   <= '0;
         gpio_in_q <= '0;
         prev_q    <= '0;
         cap_en_q  <= 1'b0;
         cap_src_q <= 1'b0;
         ovf_q     <= 1'b0;
         ts_q      <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= 9'd0;
      end else begin
         base_q    <= base_d;
         pmask_q   <= pmask_d;
         gpio_in_q <= gpio_in_d;
         prev_q    <= prev_d;
         cap_en_q  <= cap_en_d;
         cap_src_q <= cap_src_d;
         ovf_q     <= ovf_d;
         ts_q      <= ts_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
      end
   end

   // storage needs no reset: validity is tracked by count_q
   always_ff @(posedge SYSCLK_apb) begin
      if (mem_we) mem_q[wr_ptr_q] <= {ts_q, cap_cur};
   end

   // read mux
   logic [31:0] rdata;
   always_comb begin
      rdata = 32'd0;
      if (addr_hit) begin
         case (reg_idx)
            4'h0: rdata = 32'(base_q);
            4'h1: rdata = 32'(GPIO_OUT);
            4'h2: rdata = 32'(INT);
            4'h3: rdata = 32'(GPIO_OE);
            4'h4: rdata = 32'(pmask_q);
            4'h5: rdata = {31'd0, busy_q};
            4'h6: rdata = {30'd0, cap_src_q, cap_en_q};
            4'h7: rdata = cap_empty ? 32'd0 : 32'(head[IO_NUM-1:0]);
            4'h8: rdata = cap_empty ? 32'd0 : 32'(head[EW-1:IO_NUM]);
            4'h9: rdata = {13'd0, ovf_q, cap_full, cap_empty, 7'd0, count_q};
            default: rdata = 32'd0;
         endcase
      end
   end

   assign bfm.BFM_RDATA = rdata;
   assign GPIO_IN       = gpio_in_q;
   assign STIM_BUSY     = busy_q;
   assign CAP_OVF       = ovf_q;
endmodule

// File: doc/gpio_bfm_stim_capture.md
Name: gpio_bfm_stim_capture

Overview:
Parametrised stimulus/capture agent on the APB master BFM external-memory interface, driving and observing a CoreGPIO DUT in the user testbench. Replaces the fixed GPIO_IN store/readback logic with three additions:
- a programmable pulse-train generator on GPIO_IN;
- an edge-capture FIFO that timestamps changes on GPIO_OUT or INT;
- sticky overflow reporting.
BFM scripts control all of it through word-addressed registers.

Parameters:
IO_NUM, 8, GPIO channel count (1..32).
FIFO_DEPTH, 16, capture FIFO entries (power of 2, 2..256).
TS_WIDTH, 16, timestamp counter width (1..32).

Ports:
SYSCLK_apb  in  1  clock; all logic rising-edge.
PRESETN  in  1  asynchronous active-low reset.
BFM_WR  in  1  BFM external write strobe, one cycle.
BFM_RD  in  1  BFM external read strobe, one cycle.
BFM_ADDR  in  32  word address; only [3:0] decoded when [31:4]==0.
BFM_WDATA  in  32  write data.
BFM_RDATA  out  32  read data.
GPIO_IN  out  IO_NUM  drive to DUT GPIO_IN.
GPIO_OUT  in  IO_NUM  DUT output observe.
GPIO_OE  in  IO_NUM  DUT output-enable observe.
INT  in  IO_NUM  DUT interrupt observe.
STIM_BUSY  out  1  pulse train active.
CAP_OVF  out  1  sticky FIFO overflow.

Behaviour:
Reset and clocking:
- Reset is PRESETN, asynchronous, active-low; clock is SYSCLK_apb.
- Reset values: GPIO_IN=0, STIM_BUSY=0, CAP_OVF=0, FIFO empty, capture disabled, timestamp=0, all registers 0.

Register map (word address):
- 0x0 BASE RW: GPIO_IN base value.
- 0x1 OBS_OUT RO: GPIO_OUT.
- 0x2 OBS_INT RO: INT.
- 0x3 OBS_OE RO: GPIO_OE.
- 0x4 PMASK RW: pulse mask.
- 0x5 PCTRL: write [15:0]=width W, [23:16]=count N, and starts the train; read returns {31'b0,STIM_BUSY}.
- 0x6 CCTRL RW:
  - bit0 enable.
  - bit1 source (0=GPIO_OUT, 1=INT).
  - bit2 clear: write-only, self-clearing; empties FIFO and clears OVF.
- 0x7 CAP_VAL RO: head entry value; no pop.
- 0x8 CAP_TS RO: head entry timestamp; pops on BFM_RD.
- 0x9 CSTAT RO: [8:0]=count, [16]=empty, [17]=full, [18]=ovf.
- Unmapped reads return 0. Unused upper bits read 0. Writes to RO or unmapped addresses are ignored.

Read path:
- BFM_RDATA is combinational from BFM_ADDR, with zero wait.
- Register writes take effect at the clock edge where BFM_WR=1.

Pulse generator:
- GPIO_IN = BASE ^ (PMASK & {IO_NUM{phase}}), registered with 1-cycle latency.
- FSM states IDLE, HI, LO.
- A PCTRL write in IDLE with N>0 goes to HI. W=0 is treated as 1.
- HI holds phase=1 for W cycles, then goes to LO.
- LO holds phase=0 for W cycles, then decrements N. N>0 returns to HI; N=0 returns to IDLE.
- STIM_BUSY=1 whenever the FSM is not in IDLE.
- A PCTRL write while busy is ignored. A PCTRL write with N=0 is a no-op.
- BASE and PMASK writes during a train take effect on the next cycle; phase is unaffected.

Capture:
- Timestamp counter is free-running while enabled and wraps modulo 2^TS_WIDTH.
- On the 0->1 enable transition, the timestamp resets to 0 and prev loads the current source value. No entry is pushed on that cycle.
- While enabled, each cycle where source != prev pushes {ts, source} and updates prev.
- FIFO full with a push and no pop: the entry is dropped and OVF is set (sticky until clear).
- Full with simultaneous push and pop: both occur, no overflow.
- Pop on empty: no effect; CAP_VAL and CAP_TS read 0.
- Clear has priority over a same-cycle push or pop.
- Changing source while enabled: prev reloads from the new source and no push occurs that cycle.

Reset mid-operation:
- Asserting PRESETN low aborts any train, forces GPIO_IN=0, and empties the FIFO immediately.

Test Plan:
- Reset, then read 0x0..0x9 -> all 0 except CSTAT=0x10000 (empty); GPIO_IN=0.
- Write BASE=0x05, PMASK=0x81, PCTRL=0x00020003 -> GPIO_IN alternates 0x84/0x05 every 3 cycles, 2 full pulses; STIM_BUSY high 12 cycles, then low.
- Write CCTRL=0x1; DUT GPIO_OUT changes 0x00→0x3C at t=4 and 0x3C→0x00 at t=9 -> CSTAT count=2; CAP_VAL=0x3C and CAP_TS=4; after pop, CAP_VAL=0x00 and CAP_TS=9.
- FIFO_DEPTH=16 with 17 source changes and no pops -> count=16, full=1, CAP_OVF=1; write CCTRL=0x5 -> count=0, ovf=0, enable kept.
- While full, a pop and a change in the same cycle -> count stays 16, ovf stays 0; newest entry is at the tail.
- PCTRL write while busy -> ignored, train length unchanged. PRESETN pulsed low mid-train -> GPIO_IN=0 and STIM_BUSY=0 asynchronously.
